sync_mode_ctrl: RTL and testbench

Mode-qualification and configuration controller for the display-capture path. It watches the incoming TRS-80 hsync and vsync in the 126 MHz `vgaclk_x5` domain and measures line period and lines per frame. It qualifies the signal over several frames and then publishes a registered capture configuration: NCO base increment, horizontal dot total and vertical line total/blanking. The dot-clock DPLL and the capture counters consume this configuration in place of hard-wired constants.

---
 rtl/sync_mode_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_sync_mode_ctrl.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/sync_mode_ctrl.sv
// Display sync mode qualifier: measures hsync period and lines/frame, confirms a
// stable 50/60 Hz mode over several frames, then publishes the capture configuration.
module sync_mode_ctrl #(
   parameter int HPER_MIN       = 7800,
   parameter int HPER_MAX       = 8100,
   parameter int CONFIRM_FRAMES = 4
) (
   input  logic        vgaclk_x5,
   input  logic        resetn,
   input  logic        hsync_in,
   input  logic        vsync_in,
   input  logic        col80,
   output logic [30:0] nco_base,
   output logic [9:0]  h_total,
   output logic [8:0]  v_total,
   output logic [8:0]  v_blank,
   output logic        cfg_valid,
   output logic        cfg_strobe,
   output logic        rate50,
   output logic [1:0]  state,
   output logic [13:0] hper,
   output logic [9:0]  lines
);
   typedef enum logic [1:0] {NOSIG = 2'd0, MEASURE = 2'd1, CONFIRM = 2'd2, LOCKED = 2'd3} state_t;

   localparam logic [13:0] PMIN = 14'(HPER_MIN);
   localparam logic [13:0] PMAX = 14'(HPER_MAX);
   localparam logic [3:0]  CFN  = 4'(CONFIRM_FRAMES);

   logic [2:0]  hs_sr, vs_sr;
   logic [1:0]  col_sr;
   logic [13:0] pcnt;
   logic [9:0]  lcnt, line_now;
   logic        bad;
   logic        hrise, vfall, col_s, per_ok, tmo, bad_now, is60, is50, frame_ok;

   assign hrise    = hs_sr[1] & ~hs_sr[2];
   assign vfall    = ~vs_sr[1] & vs_sr[2];
   assign col_s    = col_sr[1];
   assign per_ok   = (pcnt >= PMIN) && (pcnt <= PMAX);
   assign tmo      = (pcnt == '1) || (lcnt == '1);
   // An hsync edge coinciding with the vsync fall still belongs to the ending frame.
   assign line_now = (hrise && lcnt != '1) ? lcnt + 10'd1 : lcnt;
   assign bad_now  = bad | (hrise & ~per_ok);
   assign is60     = (line_now >= 10'd262) && (line_now <= 10'd266);
   assign is50     = (line_now >= 10'd310) && (line_now <= 10'd314);
   assign frame_ok = ~bad_now & (is60 | is50);

   always_ff @(posedge vgaclk_x5 or negedge resetn) begin
      if (!resetn) begin
         hs_sr  <= '0;
         vs_sr  <= '0;
         col_sr <= '0;
         pcnt   <= '0;
         lcnt   <= '0;
         bad    <= 1'b0;
         hper   <= '0;
         lines  <= '0;
      end else begin
         hs_sr  <= {hs_sr[1:0], hsync_in};
         vs_sr  <= {vs_sr[1:0], vsync_in};
         col_sr <= {col_sr[0], col80};
         if (hrise) begin
            hper <= pcnt;
            pcnt <= 14'd1;
         end else if (pcnt != '1) begin
            pcnt <= pcnt + 14'd1;
         end
         if (vfall) lines <= line_now;
         if (tmo || vfall) begin
            lcnt <= '0;
            bad  <= 1'b0;
         end else begin
            lcnt <= line_now;
            bad  <= bad_now;
         end
      end
   end

   state_t     st_q, st_d;
   logic [3:0] cnt_q, cnt_d;
   logic       cand_q, cand_d, miss_q, miss_d, valid_d, load, ld_r50, leave, ccol_q;
   logic [8:0] vt_n;

   always_comb begin
      st_d    = st_q;
      cnt_d   = cnt_q;
      cand_d  = cand_q;
      miss_d  = miss_q;
      valid_d = cfg_valid;
      load    = 1'b0;
      ld_r50  = cand_q;
      leave   = 1'b0;
      if (tmo) begin
         st_d    = NOSIG;
         cnt_d   = '0;
         miss_d  = 1'b0;
         valid_d = 1'b0;
      end else begin
         unique case (st_q)
            NOSIG:   if (hrise && per_ok) st_d = MEASURE;
            MEASURE: if (vfall && frame_ok) begin
               cand_d = is50;
               cnt_d  = 4'd1;
               if (CFN == 4'd1) begin
                  st_d   = LOCKED;
                  load   = 1'b1;
                  ld_r50 = is50;
               end else begin
                  st_d = CONFIRM;
               end
            end
            CONFIRM: if (vfall) begin
               if (frame_ok && is50 == cand_q) begin
                  cnt_d = cnt_q + 4'd1;
                  if (cnt_q + 4'd1 == CFN) begin
                     st_d   = LOCKED;
                     load   = 1'b1;
                     miss_d = 1'b0;
                  end
               end else begin
                  leave = 1'b1;
               end
            end
            LOCKED: if (vfall) begin
               // One bad frame is forgiven; a second in a row drops lock.
               if (!frame_ok) begin
                  if (miss_q) leave = 1'b1;
                  else        miss_d = 1'b1;
               end else if (is50 != cand_q) begin
                  leave = 1'b1;
               end else begin
                  miss_d = 1'b0;
               end
            end
         endcase
         if (leave) begin
            st_d    = MEASURE;
            cnt_d   = '0;
            miss_d  = 1'b0;
            valid_d = 1'b0;
         end
         if (st_q == LOCKED && !leave && col_s != ccol_q) load = 1'b1;
         if (load) valid_d = 1'b1;
      end
   end

   assign vt_n  = ld_r50 ? 9'd312 : 9'd264;
   assign state = st_q;

   always_ff @(posedge vgaclk_x5 or negedge resetn) begin
      if (!resetn) begin
         st_q       <= NOSIG;
         cnt_q      <= '0;
         cand_q     <= 1'b0;
         miss_q     <= 1'b0;
         cfg_valid  <= 1'b0;
         cfg_strobe <= 1'b0;
         rate50     <= 1'b0;
         ccol_q     <= 1'b0;
         nco_base   <= 31'h0A4C6B6F;
         h_total    <= 10'd640;
         v_total    <= 9'd264;
         v_blank    <= 9'd72;
      end else begin
         st_q       <= st_d;
         cnt_q      <= cnt_d;
         cand_q     <= cand_d;
         miss_q     <= miss_d;
         cfg_valid  <= valid_d;
         cfg_strobe <= load;
         if (load) begin
            nco_base <= col_s ? 31'h0CDF864A : 31'h0A4C6B6F;
            h_total  <= col_s ? 10'd800 : 10'd640;
            v_total  <= vt_n;
            v_blank  <= vt_n - (col_s ? 9'd240 : 9'd192);
            rate50   <= ld_r50;
            ccol_q   <= col_s;
         end
      end
   end
endmodule

// File: tb/tb_sync_mode_ctrl.sv
// Directed bench for sync_mode_ctrl with a short hsync period (8 clocks, legal 6..10)
// so whole frames fit in the run; output events are matched against a scoreboard.
module tb_sync_mode_ctrl;
   logic        clk = 1'b0, resetn = 1'b0, hsync = 1'b0, vsync = 1'b1, col80 = 1'b0;
   logic [30:0] nco_base;
   logic [9:0]  h_total, lines;
   logic [8:0]  v_total, v_blank;
   logic        cfg_valid, cfg_strobe, rate50;
   logic [1:0]  state;
   logic [13:0] hper;

   always #4 clk = ~clk;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   sync_mode_ctrl #(.HPER_MIN(6), .HPER_MAX(10), .CONFIRM_FRAMES(4)) dut (
      .vgaclk_x5(clk), .resetn(resetn), .hsync_in(hsync), .vsync_in(vsync), .col80(col80),
      .nco_base(nco_base), .h_total(h_total), .v_total(v_total), .v_blank(v_blank),
      .cfg_valid(cfg_valid), .cfg_strobe(cfg_strobe), .rate50(rate50), .state(state),
      .hper(hper), .lines(lines));

   typedef struct {
      int          cyc;
      int          st;
      bit          v, s, r;
      logic [30:0] nco;
      int          h, vt, vb;
   } evt_t;

   evt_t sb[$];
   evt_t pend_h, pend_v, tmp;
   bit   arm_h = 0, arm_v = 0;
   int   last_h = 0;
   int   npass = 0, ntot = 0;

   function automatic evt_t ev(int st, bit v, bit s, bit c80, bit r50);
      evt_t e;
      e.cyc = 0; e.st = st; e.v = v; e.s = s; e.r = r50;
      e.nco = c80 ? 31'h0CDF864A : 31'h0A4C6B6F;
      e.h   = c80 ? 800 : 640;
      e.vt  = r50 ? 312 : 264;
      e.vb  = c80 ? (r50 ? 72 : 24) : (r50 ? 120 : 72);
      return e;
   endfunction

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      ntot++;
      assert (obs === exp) npass++;
      else $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
   endtask

   task automatic chk_reset();
      chk("rst_state", 32'(state), 0);
      chk("rst_valid", 32'(cfg_valid), 0);
      chk("rst_strobe", 32'(cfg_strobe), 0);
      chk("rst_rate50", 32'(rate50), 0);
      chk("rst_hper", 32'(hper), 0);
      chk("rst_lines", 32'(lines), 0);
      chk("rst_nco", 32'(nco_base), 32'h0A4C6B6F);
      chk("rst_htotal", 32'(h_total), 640);
      chk("rst_vtotal", 32'(v_total), 264);
      chk("rst_vblank", 32'(v_blank), 72);
   endtask

   task automatic tick();
      @(posedge clk); #1;
   endtask

   // One line: 2-clock hsync pulse; optionally drop vsync after it to end the frame.
   task automatic line(int per, bit vf);
      hsync = 1'b1;
      last_h = cyc;
      if (arm_h) begin pend_h.cyc = cyc + 3; sb.push_back(pend_h); arm_h = 0; end
      tick(); tick();
      hsync = 1'b0;
      if (vf) begin
         vsync = 1'b0;
         if (arm_v) begin pend_v.cyc = cyc + 3; sb.push_back(pend_v); arm_v = 0; end
      end
      repeat (per - 2) tick();
   endtask

   task automatic frame(int n, int badl);
      for (int i = 0; i < n; i++) begin
         if (i == 0) vsync = 1'b1;
         line((i == badl) ? 4 : 8, i == n - 1);
      end
   endtask

   // Every state change or strobe must match the next queued expectation.
   initial begin
      logic [1:0] prev;
      evt_t e;
      prev = 2'd0;
      forever begin
         @(negedge clk);
         if (!resetn) prev = 2'd0;
         else if (state !== prev || cfg_strobe) begin
            ntot++;
            assert (sb.size() > 0) npass++;
            else $error("FAIL evt_unexpected: got state %0d strobe %0b at cycle %0d expected no event",
                        state, cfg_strobe, cyc);
            if (sb.size() > 0) begin
               e = sb.pop_front();
               chk("evt_cycle", 32'(cyc), 32'(e.cyc));
               chk("evt_state", 32'(state), 32'(e.st));
               chk("evt_valid", 32'(cfg_valid), 32'(e.v));
               chk("evt_strobe", 32'(cfg_strobe), 32'(e.s));
               chk("evt_rate50", 32'(rate50), 32'(e.r));
               chk("evt_nco", 32'(nco_base), 32'(e.nco));
               chk("evt_htotal", 32'(h_total), 32'(e.h));
               chk("evt_vtotal", 32'(v_total), 32'(e.vt));
               chk("evt_vblank", 32'(v_blank), 32'(e.vb));
            end
            prev = state;
         end
      end
   end

   initial begin
      repeat (3) tick();
      chk_reset();
      resetn = 1'b1;
      repeat (20) tick();

      // Acquire: first period is bogus, second qualifies; short priming frame is bad.
      line(8, 0);
      pend_h = ev(1, 0, 0, 0, 0); arm_h = 1;
      frame(5, -1);
      pend_v = ev(2, 0, 0, 0, 0); arm_v = 1;
      frame(264, -1);
      frame(264, -1);
      frame(264, -1);
      pend_v = ev(3, 1, 1, 0, 0); arm_v = 1;
      frame(264, -1);
      chk("hper_nominal", 32'(hper), 8);
      chk("lines_60", 32'(lines), 264);
      chk("strobe_low_after_lock", 32'(cfg_strobe), 0);

      // Locked: a single bad frame is tolerated, two in a row drop to MEASURE.
      frame(264, 10);
      frame(264, -1);
      frame(264, 10);
      pend_v = ev(1, 0, 0, 0, 0); arm_v = 1;
      frame(264, 10);
      chk("hper_after_bad", 32'(hper), 8);

      // Class change mid-confirm restarts; then lock at 50 Hz.
      pend_v = ev(2, 0, 0, 0, 0); arm_v = 1;
      frame(264, -1);
      frame(264, -1);
      pend_v = ev(1, 0, 0, 0, 0); arm_v = 1;
      frame(312, -1);
      pend_v = ev(2, 0, 0, 0, 0); arm_v = 1;
      frame(312, -1);
      frame(312, -1);
      frame(312, -1);
      pend_v = ev(3, 1, 1, 0, 1); arm_v = 1;
      frame(312, -1);
      chk("lines_50", 32'(lines), 312);

      // Column mode change while locked reloads without leaving LOCKED.
      col80 = 1'b1;
      tmp = ev(3, 1, 1, 1, 1); tmp.cyc = cyc + 3; sb.push_back(tmp);
      frame(312, -1);
      chk("locked_after_col", 32'(state), 3);
      chk("valid_after_col", 32'(cfg_valid), 1);

      // Loss of hsync: NOSIG 16383 clocks after the last detected edge.
      tmp = ev(0, 0, 0, 1, 1); tmp.cyc = last_h + 3 + 16383; sb.push_back(tmp);
      repeat (16400) tick();
      chk("nosig_after_timeout", 32'(state), 0);

      // Re-acquire into CONFIRM, then reset mid-frame.
      line(8, 0);
      pend_h = ev(1, 0, 0, 1, 1); arm_h = 1;
      frame(5, -1);
      pend_v = ev(2, 0, 0, 1, 1); arm_v = 1;
      frame(312, -1);
      frame(312, -1);
      for (int i = 0; i < 50; i++) line(8, 0);
      chk("pre_reset_confirm", 32'(state), 2);
      resetn = 1'b0;
      #1;
      chk_reset();
      tick();
      resetn = 1'b1;
      repeat (10) tick();
      chk("sb_empty", 32'(sb.size()), 0);

      $display("%0d/%0d checks passed", npass, ntot);
      $finish;
   end
endmodule
